// File: rtl/alu_cmd_ctrl_if.sv
// Stream and ALU handshake bundle for alu_cmd_ctrl.
// master: the sequencer's view; slave: the command source, ALU and result sink.
interface alu_cmd_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [3:0]            alu_fun;
   logic                  alu_req;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_res_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_err;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      input  in_data, in_valid, alu_res, alu_res_valid, out_ready,
      output in_ready, alu_a, alu_b, alu_fun, alu_req, out_data, out_err, out_valid
   );

   modport slave (
      output in_data, in_valid, alu_res, alu_res_valid, out_ready,
      input  in_ready, alu_a, alu_b, alu_fun, alu_req, out_data, out_err, out_valid
   );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command sequencer: opcode/A/B frame in, one ALU request, result out.
// Optional ALU wait timeout is compiled in with ALU_CMD_CTRL_TIMEOUT_EN.
module alu_cmd_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   alu_cmd_ctrl_if.master io_bus,
   output logic [7:0]     o_cmd_cnt
);

   if (DATA_WIDTH < 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("alu_cmd_ctrl: DATA_WIDTH must be >= 4 and TIMEOUT in 1..255");
   end

   typedef enum logic [2:0] {StIdle, StGetA, StGetB, StWait, StSend} state_e;

   state_e                r_state;
   logic                  r_in_ready;
   logic [DATA_WIDTH-1:0] r_alu_a;
   logic [DATA_WIDTH-1:0] r_alu_b;
   logic [3:0]            r_alu_fun;
   logic                  r_alu_req;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic [7:0]            r_cmd_cnt;
   logic                  w_in_hs;

`ifdef ALU_CMD_CTRL_TIMEOUT_EN
   // Counter holds completed idle WAIT cycles; the last one allowed is TIMEOUT-1.
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
   logic [7:0]            r_wait_cnt;
   logic                  r_out_err;
`endif

   assign w_in_hs = io_bus.in_valid && r_in_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_in_ready  <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_fun   <= '0;
         r_alu_req   <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_cmd_cnt   <= '0;
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
         r_wait_cnt  <= '0;
         r_out_err   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               r_in_ready <= 1'b1;
               if (w_in_hs) begin
                  r_alu_fun <= io_bus.in_data[3:0];
                  r_state   <= StGetA;
               end
            end
            StGetA: begin
               if (w_in_hs) begin
                  r_alu_a <= io_bus.in_data;
                  r_state <= StGetB;
               end
            end
            StGetB: begin
               if (w_in_hs) begin
                  r_alu_b    <= io_bus.in_data;
                  r_in_ready <= 1'b0;
                  r_alu_req  <= 1'b1;
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
                  r_wait_cnt <= '0;
`endif
                  r_state    <= StWait;
               end
            end
            StWait: begin
               // A result arriving on the final allowed cycle beats the timeout.
               if (io_bus.alu_res_valid) begin
                  r_out_data  <= io_bus.alu_res;
                  r_alu_req   <= 1'b0;
                  r_out_valid <= 1'b1;
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
                  r_out_err   <= 1'b0;
`endif
                  r_state     <= StSend;
               end
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
               else if (r_wait_cnt == TimeoutLast) begin
                  r_out_data  <= '1;
                  r_out_err   <= 1'b1;
                  r_alu_req   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= StSend;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
`endif
            end
            StSend: begin
               if (io_bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_cmd_cnt   <= r_cmd_cnt + 8'd1;
                  r_in_ready  <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.alu_a     = r_alu_a;
   assign io_bus.alu_b     = r_alu_b;
   assign io_bus.alu_fun   = r_alu_fun;
   assign io_bus.alu_req   = r_alu_req;
   assign io_bus.out_data  = r_out_data;
   assign io_bus.out_valid = r_out_valid;
   assign o_cmd_cnt        = r_cmd_cnt;

`ifdef ALU_CMD_CTRL_TIMEOUT_EN
   assign io_bus.out_err = r_out_err;
`else
   assign io_bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: directed frames, a behavioural ALU
// responder with programmable latency, and a decoupled output monitor.
module tb_alu_cmd_ctrl;
   localparam int unsigned DW = 8;
   localparam int unsigned TO = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cmd_cnt;

   alu_cmd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   alu_cmd_ctrl #(
      .DATA_WIDTH(DW),
      .TIMEOUT   (TO)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .io_bus   (bus),
      .o_cmd_cnt(cmd_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int n_out = 0;
   logic [8:0] sb[$];

   // ALU responder controls
   int         lat = 0;
   bit         res_en = 1'b1;
   bit         spurious = 1'b0;
   logic [3:0] exp_fun = '0;
   logic [7:0] exp_a = '0;
   logic [7:0] exp_b = '0;
   int         w = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bound expired", name);
   endtask

   function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] a,
                                         input logic [7:0] b);
      case (f)
         4'h0:    return a + b;
         4'h7:    return a ^ b;
         default: return a - b;
      endcase
   endfunction

   // Behavioural ALU: result valid once the request has been up for lat+1 cycles.
   initial begin
      bus.alu_res_valid = 1'b0;
      bus.alu_res = '0;
      forever begin
         @(negedge clk);
         if (bus.alu_req) begin
            w++;
            check("alu_fun", bus.alu_fun, exp_fun);
            check("alu_a", bus.alu_a, exp_a);
            check("alu_b", bus.alu_b, exp_b);
            bus.alu_res = alu_fn(bus.alu_fun, bus.alu_a, bus.alu_b);
            bus.alu_res_valid = res_en && (w > lat);
         end else begin
            w = 0;
            bus.alu_res = 8'h5A;
            bus.alu_res_valid = spurious;
         end
      end
   end

   // Monitor: pops the scoreboard on every output handshake.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: actual=0x%0h required=none", bus.out_data);
            end else begin
               e = sb.pop_front();
               check("out_data", bus.out_data, e[7:0]);
               check("out_err", bus.out_err, e[8]);
            end
            n_out++;
         end
      end
   end

   task automatic send_word(input logic [7:0] wd, input int gap);
      int n;
      bus.in_valid = 1'b0;
      bus.in_data = 8'hEE;
      repeat (gap) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = wd;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) fail("in_ready_wait");
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data = 8'hEE;
   endtask

   // mode 0: normal result expected, 1: timeout error word, 2: no output
   task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                             input int l, input int gap, input int mode);
      lat = l;
      exp_fun = op[3:0];
      exp_a = a;
      exp_b = b;
      if (mode == 0) sb.push_back({1'b0, alu_fn(op[3:0], a, b)});
      else if (mode == 1) sb.push_back(9'h1FF);
      send_word(op, gap);
      send_word(a, gap);
      send_word(b, gap);
   endtask

   task automatic wait_out(input int target);
      int n;
      n = 0;
      while (n_out < target && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail("out_wait");
   endtask

   initial begin
      int n;
      int base;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_alu_a", bus.alu_a, 0);
      check("rst_alu_b", bus.alu_b, 0);
      check("rst_alu_fun", bus.alu_fun, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_cmd_cnt", cmd_cnt, 0);
      check("rst_alu_req", bus.alu_req, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_err", bus.out_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);

      // Add frame: result 2 edges after B accept
      send_frame(8'h00, 8'h05, 8'h03, 0, 0, 0);
      check("lat_req_up", bus.alu_req, 1);
      check("lat_valid_early", bus.out_valid, 0);
      check("lat_in_ready_low", bus.in_ready, 0);
      @(negedge clk);
      check("lat_valid", bus.out_valid, 1);
      check("lat_data", bus.out_data, 8'h08);
      check("lat_err", bus.out_err, 0);
      wait_out(1);
      check("cnt_1", cmd_cnt, 1);
      check("ready_after_send", bus.in_ready, 1);

      // Backpressure on the output
      bus.out_ready = 1'b0;
      send_frame(8'h07, 8'hF0, 8'h0F, 2, 0, 0);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail("stall_valid_wait");
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", bus.out_valid, 1);
         check("stall_data", bus.out_data, 8'hFF);
         check("stall_in_ready", bus.in_ready, 0);
         check("stall_cnt", cmd_cnt, 1);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      wait_out(2);
      check("cnt_2", cmd_cnt, 2);

      // Gapped input and result-valid noise outside WAIT
      spurious = 1'b1;
      send_frame(8'h03, 8'h20, 8'h07, 1, 1, 0);
      wait_out(3);
      spurious = 1'b0;
      check("cnt_3", cmd_cnt, 3);

      // Upper opcode bits dropped
      send_frame(8'hAB, 8'h10, 8'h01, 0, 0, 0);
      check("opcode_fun", bus.alu_fun, 4'hB);
      wait_out(4);
      check("cnt_4", cmd_cnt, 4);

      // Reset while waiting on the ALU
      res_en = 1'b0;
      send_frame(8'h01, 8'h33, 8'h11, 0, 0, 2);
      repeat (3) @(negedge clk);
      check("midwait_req", bus.alu_req, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_req", bus.alu_req, 0);
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_cnt", cmd_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      res_en = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_valid_after", bus.out_valid, 0);
      check("midrst_cnt_after", cmd_cnt, 0);

      // Counter wrap
      base = n_out;
      for (int i = 0; i < 256; i++) begin
         send_frame(8'h00, 8'(i), 8'h01, 0, 0, 0);
         wait_out(base + i + 1);
         if (i == 254) check("cnt_255", cmd_cnt, 255);
      end
      check("cnt_wrap", cmd_cnt, 0);

`ifdef ALU_CMD_CTRL_TIMEOUT_EN
      res_en = 1'b0;
      base = n_out;
      send_frame(8'h02, 8'h44, 8'h04, 0, 0, 1);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         if (bus.alu_req) n++;
         @(negedge clk);
      end
      check("to_wait_cycles", n, 15);
      check("to_data", bus.out_data, 8'hFF);
      check("to_err", bus.out_err, 1);
      check("to_req_low", bus.alu_req, 0);
      wait_out(base + 1);
      check("to_cnt", cmd_cnt, 1);
      res_en = 1'b1;
      send_frame(8'h02, 8'h44, 8'h04, 14, 0, 0);
      wait_out(base + 2);
      check("to_race_cnt", cmd_cnt, 2);
`endif

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
